// File: rtl/video_proc_pkg.sv
// Shared definitions for the video front end: arbiter states, default geometry and the pixel beat layout.
// Used by video_frame_arbiter and frame_geometry_checker.
package video_proc_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_t;

    localparam logic [15:0] DEF_IMG_HDISP = 16'd640;
    localparam logic [15:0] DEF_IMG_VDISP = 16'd480;

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       clken;
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } vid_beat_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_geometry_checker.sv
// Counts pixels per line and lines per frame of the forwarded stream and flags geometry mismatches.
// err_o is combinational and valid on the frame-end cycle; no backpressure, observes the stream only.
module frame_geometry_checker
    import video_proc_pkg::*;
#(
    parameter logic [15:0] IMG_HDISP = DEF_IMG_HDISP,
    parameter logic [15:0] IMG_VDISP = DEF_IMG_VDISP
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic active_i,
    input  logic href_i,
    input  logic href_fall_i,
    input  logic clken_i,
    input  logic frame_end_i,
    output logic err_o
);

    logic [15:0] pix_cnt_q;
    logic [15:0] pix_cnt_d;
    logic [15:0] line_cnt_q;
    logic [15:0] line_cnt_d;
    logic        sticky_q;
    logic        sticky_d;

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        sticky_d   = sticky_q;
        if (clear_i) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            sticky_d   = 1'b0;
        end else if (active_i) begin
            if (href_i && clken_i) begin
                pix_cnt_d = sat_inc16(pix_cnt_q);
            end
            if (href_fall_i) begin
                if (pix_cnt_q != IMG_HDISP) begin
                    sticky_d = 1'b1;
                end
                line_cnt_d = sat_inc16(line_cnt_q);
                pix_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    // Next-state values so a line ending on the frame-end cycle is still judged.
    assign err_o = frame_end_i & (sticky_d | (line_cnt_d != IMG_VDISP));

endmodule

// File: rtl/video_frame_arbiter.sv
// Two-source RGB888 frame arbiter feeding one pipeline; switches source only between whole frames.
// post_* latency 1 cycle, no backpressure (ungranted source dropped); FRAME_CHECK_EN enables geometry checking.
module video_frame_arbiter
    import video_proc_pkg::*;
#(
    parameter logic [15:0] IMG_HDISP = DEF_IMG_HDISP,
    parameter logic [15:0] IMG_VDISP = DEF_IMG_VDISP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       src0_vsync,
    input  logic       src0_href,
    input  logic       src0_clken,
    input  logic [7:0] src0_red,
    input  logic [7:0] src0_green,
    input  logic [7:0] src0_blue,
    input  logic       src1_vsync,
    input  logic       src1_href,
    input  logic       src1_clken,
    input  logic [7:0] src1_red,
    input  logic [7:0] src1_green,
    input  logic [7:0] src1_blue,
    input  logic       sel_req,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue,
    output logic       grant,
    output logic       frame_done,
    output logic       frame_err
);

    vid_beat_t  src0_beat;
    vid_beat_t  src1_beat;
    vid_beat_t  gnt_beat;
    vid_beat_t  post_d;
    vid_beat_t  post_q;
    arb_state_t state_q;
    logic       grant_q;
    logic       frame_done_q;
    logic       src0_vs_q;
    logic       src1_vs_q;
    logic       gnt_vs_prev;
    logic       vs_rise;
    logic       vs_fall;
    logic       switch_req;
    logic       frame_start;
    logic       frame_end;

    assign src0_beat = '{vsync: src0_vsync, href: src0_href, clken: src0_clken,
                         red: src0_red, green: src0_green, blue: src0_blue};
    assign src1_beat = '{vsync: src1_vsync, href: src1_href, clken: src1_clken,
                         red: src1_red, green: src1_green, blue: src1_blue};

    assign gnt_beat    = grant_q ? src1_beat : src0_beat;
    assign gnt_vs_prev = grant_q ? src1_vs_q : src0_vs_q;
    assign vs_rise     = gnt_beat.vsync & ~gnt_vs_prev;
    assign vs_fall     = ~gnt_beat.vsync & gnt_vs_prev;
    assign switch_req  = sel_req ^ grant_q;

    // A pending switch wins over a coincident vsync rise, so that frame is never started.
    assign frame_start = (state_q == ST_ARMED) & vs_rise & ~switch_req;
    assign frame_end   = (state_q == ST_ACTIVE) & vs_fall;
    assign post_d      = ((state_q == ST_ACTIVE) | frame_start) ? gnt_beat : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src0_vs_q <= 1'b0;
            src1_vs_q <= 1'b0;
        end else begin
            src0_vs_q <= src0_vsync;
            src1_vs_q <= src1_vsync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            grant_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                ST_SYNC: begin
                    if (switch_req) begin
                        grant_q <= sel_req;
                    end else if (!gnt_beat.vsync) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (switch_req) begin
                        grant_q <= sel_req;
                        state_q <= ST_SYNC;
                    end else if (frame_start) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_end) begin
                        frame_done_q <= 1'b1;
                        if (switch_req) begin
                            grant_q <= sel_req;
                            state_q <= ST_SYNC;
                        end else begin
                            state_q <= ST_ARMED;
                        end
                    end
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_q <= '0;
        end else begin
            post_q <= post_d;
        end
    end

    assign post_frame_vsync = post_q.vsync;
    assign post_frame_href  = post_q.href;
    assign post_frame_clken = post_q.clken;
    assign post_img_red     = post_q.red;
    assign post_img_green   = post_q.green;
    assign post_img_blue    = post_q.blue;
    assign grant            = grant_q;
    assign frame_done       = frame_done_q;

`ifdef FRAME_CHECK_EN
    logic src0_hs_q;
    logic src1_hs_q;
    logic gnt_hs_fall;
    logic geom_err;
    logic frame_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src0_hs_q <= 1'b0;
            src1_hs_q <= 1'b0;
        end else begin
            src0_hs_q <= src0_href;
            src1_hs_q <= src1_href;
        end
    end

    assign gnt_hs_fall = ~gnt_beat.href & (grant_q ? src1_hs_q : src0_hs_q);

    frame_geometry_checker #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_geom_chk (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (frame_start),
        .active_i    (state_q == ST_ACTIVE),
        .href_i      (gnt_beat.href),
        .href_fall_i (gnt_hs_fall),
        .clken_i     (gnt_beat.clken),
        .frame_end_i (frame_end),
        .err_o       (geom_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= geom_err;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
